instr_queue: RTL



---
 rtl/mmm_pkg.sv | 14 +
 rtl/instr_queue.sv | 98 +++++++++
 2 files changed

// File: rtl/mmm_pkg.sv
// Shared core definitions: widths and the instruction-queue entry type.
// Imported by the fetch/decode decoupling logic.
package mmm_pkg;

  localparam int XLEN     = 32;
  localparam int ILEN     = 32;
  localparam int IQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO with valid/ready on both sides.
// Flush discards all entries; ready depends only on registered state.
module instr_queue
  import mmm_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [ILEN-1:0]            fetch_instr_i,
  input  logic [XLEN-1:0]            fetch_pc_i,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [ILEN-1:0]            issue_instr_o,
  output logic [XLEN-1:0]            issue_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_entry_t     mem [DEPTH];
  iq_entry_t     head;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  assign fetch_ready_o = (cnt_q != CW'(DEPTH));
  assign issue_valid_o = (cnt_q != '0);
  assign push          = fetch_valid_i & fetch_ready_o;
  assign pop           = issue_valid_o & issue_ready_i;
  assign count_o       = cnt_q;

  assign head          = mem[rd_q];
  assign issue_instr_o = issue_valid_o ? head.instr : '0;
  assign issue_pc_o    = issue_valid_o ? head.pc : '0;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push && !flush_i) begin
      mem[wr_q] <= '{pc: fetch_pc_i, instr: fetch_instr_i};
    end
  end

  a_cnt_max : assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
    cnt_q <= CW'(DEPTH));

  a_cnt_ptr : assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
    cnt_q[PW-1:0] == PW'(wr_q - rd_q));

  a_no_pop_empty : assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
    pop |-> (cnt_q != '0));

  a_hold : assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
    (fetch_valid_i && !fetch_ready_o && !flush_i)
    |=> (fetch_valid_i && $stable(fetch_pc_i)
         && $stable(fetch_instr_i)));

endmodule
